uart_rx_fifo: RTL and testbench

Parametrised UART receiver with an internal receive FIFO, the synthesizable successor to the single-byte, fixed-8N1 receive path on the SOC's RXD pin. It oversamples the asynchronous RXD line at mid-bit and supports configurable data width, parity and stop bits. It reports framing, parity and overrun errors as sticky flags. Received words are buffered so the RV32I core can drain a whole command line (e.g. "578\r") with polled loads, without per-byte deadlines.

---
 rtl/uart_pkg.sv | 11 +
 rtl/sync_fifo.sv | 44 ++++
 rtl/uart_rx_fifo.sv | 146 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, receiver FSM state type and parity helper
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD = 1;
  localparam int PAR_EVEN = 2;
  localparam int CLKS_PER_BIT_115200 = 87;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
  function automatic logic parity_bad(input logic data_xor, input logic sample, input int mode);
    return (data_xor ^ sample) != (mode == PAR_ODD);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word fall-through FIFO with occupancy count, shared by the UART RX and TX paths
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign o_empty = r_count == '0;
  assign o_full = r_count == (AW+1)'(DEPTH);
  assign w_pop = i_rd_en & ~o_empty;
  // a write to a full FIFO is accepted only when a pop frees a slot in the same cycle
  assign w_push = i_wr_en & (~o_full | w_pop);
  assign o_rd_data = o_empty ? '0 : r_mem[r_rptr];
  assign o_count = r_count;
  // storage needs no reset: empty gating hides stale entries
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wr_data;
  end
  // pointers wrap naturally at power-of-two depth; count tracks push minus pop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: mid-bit sampling UART receiver with sticky error flags feeding a receive FIFO
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY = PAR_NONE,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rxd,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  input  logic                          err_clr
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  logic r_s1, r_s2, w_rxs;
  state_t r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [2:0] r_bit, w_bit_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n;
  logic r_pbad, w_pbad_n, r_sbad, w_sbad_n;
  logic w_tick, w_push, w_ferr, w_perr, w_ovr, w_full, w_empty;
  logic r_ferr, r_perr, r_ovr;
  assign w_rxs = r_s2;
  assign w_tick = r_cnt == CW'(CLKS_PER_BIT - 1);
  // two-flop synchronizer idles high so reset never looks like a start edge
  always_ff @(posedge clk) begin
    r_s1 <= reset ? 1'b1 : rxd;
    r_s2 <= reset ? 1'b1 : r_s1;
  end
  // receiver state, bit timing and frame accumulation registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_bit <= '0;
      r_shift <= '0;
      r_pbad <= 1'b0;
      r_sbad <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt <= w_cnt_n;
      r_bit <= w_bit_n;
      r_shift <= w_shift_n;
      r_pbad <= w_pbad_n;
      r_sbad <= w_sbad_n;
    end
  end
  // next-state logic: start confirmed at half a bit, every later bit sampled one full bit apart
  always_comb begin
    w_state_n = r_state;
    w_cnt_n = r_cnt + CW'(1);
    w_bit_n = r_bit;
    w_shift_n = r_shift;
    w_pbad_n = r_pbad;
    w_sbad_n = r_sbad;
    w_push = 1'b0;
    w_ferr = 1'b0;
    w_perr = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_n = '0;
        w_bit_n = '0;
        w_pbad_n = 1'b0;
        w_sbad_n = 1'b0;
        w_state_n = w_rxs ? S_IDLE : S_START;
      end
      S_START: begin
        if (r_cnt == CW'(HALF - 1)) begin
          w_cnt_n = '0;
          w_state_n = w_rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_cnt_n = '0;
          w_shift_n = {w_rxs, r_shift[DATA_BITS-1:1]};
          w_bit_n = r_bit + 3'd1;
          if (r_bit == 3'(DATA_BITS - 1)) begin
            w_bit_n = '0;
            w_state_n = (PARITY != PAR_NONE) ? S_PAR : S_STOP;
          end
        end
      end
      S_PAR: begin
        if (w_tick) begin
          w_cnt_n = '0;
          w_pbad_n = parity_bad(^r_shift, w_rxs, PARITY);
          w_perr = w_pbad_n;
          w_state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_cnt_n = '0;
          w_ferr = ~w_rxs;
          w_sbad_n = r_sbad | ~w_rxs;
          w_bit_n = r_bit + 3'd1;
          if (r_bit == 3'(STOP_BITS - 1)) begin
            w_push = ~w_sbad_n & ~r_pbad;
            w_state_n = S_IDLE;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end
  // a full FIFO drops the word unless the reader pops in the same cycle
  assign w_ovr = w_push & w_full & ~rd_en;
  // sticky flags: a new error outranks a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ferr <= 1'b0;
      r_perr <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      r_ferr <= w_ferr | (r_ferr & ~err_clr);
      r_perr <= w_perr | (r_perr & ~err_clr);
      r_ovr <= w_ovr | (r_ovr & ~err_clr);
    end
  end
  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .i_wr_en(w_push),
    .i_wr_data(w_shift_n),
    .i_rd_en(rd_en),
    .o_rd_data(rd_data),
    .o_count(count),
    .o_full(w_full),
    .o_empty(w_empty)
  );
  assign rd_valid = ~w_empty;
  assign frame_err = r_ferr;
  assign parity_err = r_perr;
  assign overrun = r_ovr;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed checks of an 8N1 receiver and a 7E1 receiver sharing one clock
module tb_uart_rx_fifo;
  localparam int CPB = 87;
  logic clk = 1'b0, reset = 1'b1;
  logic rxd_a = 1'b1, rd_en_a = 1'b0, clr_a = 1'b0;
  logic rxd_b = 1'b1, rd_en_b = 1'b0, clr_b = 1'b0;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic val_a, val_b, fe_a, pe_a, ov_a, fe_b, pe_b, ov_b;
  logic [2:0] cnt_a, cnt_b;
  int n_chk = 0, n_err = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .rxd(rxd_a), .rd_en(rd_en_a), .rd_data(data_a), .rd_valid(val_a),
    .count(cnt_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a), .err_clr(clr_a));

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .rxd(rxd_b), .rd_en(rd_en_b), .rd_data(data_b), .rd_valid(val_b),
    .count(cnt_b), .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b), .err_clr(clr_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] fr(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  task automatic send(input logic [9:0] f, input bit to_b, input int gap);
    for (int i = 0; i < 10; i++) begin
      if (to_b) rxd_b = f[i];
      else rxd_a = f[i];
      repeat (CPB) @(negedge clk);
    end
    rxd_a = 1'b1;
    rxd_b = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pop_a();
    rd_en_a = 1'b1;
    @(negedge clk);
    rd_en_a = 1'b0;
  endtask

  task automatic clear_a();
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    while (exp_q.size() > 0) begin
      chk(tag, {24'h0, data_a}, {24'h0, exp_q.pop_front()});
      pop_a();
    end
    chk({tag, " empty"}, {31'h0, val_a}, 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset valid", {31'h0, val_a}, 32'h0);
    chk("reset count", {29'h0, cnt_a}, 32'h0);
    chk("reset data", {24'h0, data_a}, 32'h0);
    chk("reset flags", {29'h0, fe_a, pe_a, ov_a}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    send(fr(8'h35), 0, 3000);
    send(fr(8'h37), 0, 3000);
    send(fr(8'h38), 0, 3000);
    send(fr(8'h0D), 0, 3000);
    chk("t1 count", {29'h0, cnt_a}, 32'd4);
    chk("t1 valid", {31'h0, val_a}, 32'h1);
    exp_q = '{8'h35, 8'h37, 8'h38, 8'h0D};
    drain_check("t1 head");
    chk("t1 drained data", {24'h0, data_a}, 32'h0);
    chk("t1 drained count", {29'h0, cnt_a}, 32'h0);

    send(fr(8'h31), 0, 20);
    send(fr(8'h34), 0, 20);
    send(fr(8'h41), 0, 20);
    send(fr(8'h33), 0, 20);
    chk("t2 no early overrun", {31'h0, ov_a}, 32'h0);
    send(fr(8'h0D), 0, 20);
    chk("t2 overrun", {31'h0, ov_a}, 32'h1);
    chk("t2 count", {29'h0, cnt_a}, 32'd4);
    clear_a();
    chk("t2 overrun cleared", {31'h0, ov_a}, 32'h0);
    exp_q = '{8'h31, 8'h34, 8'h41, 8'h33};
    drain_check("t2 head");

    send(fr(8'h31), 0, 20);
    send(fr(8'h32), 0, 20);
    send(fr(8'h33), 0, 20);
    send(fr(8'h34), 0, 20);
    chk("t3 full", {29'h0, cnt_a}, 32'd4);
    fork
      send(fr(8'h35), 0, 20);
      begin
        repeat (828) @(negedge clk);
        rd_en_a = 1'b1;
        @(negedge clk);
        rd_en_a = 1'b0;
      end
    join
    chk("t3 no overrun", {31'h0, ov_a}, 32'h0);
    chk("t3 count", {29'h0, cnt_a}, 32'd4);
    exp_q = '{8'h32, 8'h33, 8'h34, 8'h35};
    drain_check("t3 head");

    send({1'b0, 8'h41, 1'b0}, 0, 300);
    chk("t4 frame_err", {31'h0, fe_a}, 32'h1);
    chk("t4 count", {29'h0, cnt_a}, 32'h0);
    chk("t4 parity_err", {31'h0, pe_a}, 32'h0);
    clear_a();
    chk("t4 frame_err cleared", {31'h0, fe_a}, 32'h0);
    rxd_a = 1'b0;
    repeat (26) @(negedge clk);
    rxd_a = 1'b1;
    repeat (300) @(negedge clk);
    chk("t4 glitch count", {29'h0, cnt_a}, 32'h0);
    chk("t4 glitch flags", {29'h0, fe_a, pe_a, ov_a}, 32'h0);

    send({1'b1, 1'b0, 7'h41, 1'b0}, 1, 20);
    chk("t5 valid", {31'h0, val_b}, 32'h1);
    chk("t5 data", {25'h0, data_b}, 32'h41);
    chk("t5 no parity_err", {31'h0, pe_b}, 32'h0);
    send({1'b1, 1'b1, 7'h41, 1'b0}, 1, 20);
    chk("t5 parity_err", {31'h0, pe_b}, 32'h1);
    chk("t5 bad not pushed", {29'h0, cnt_b}, 32'd1);
    send({1'b1, 1'b1, 7'h43, 1'b0}, 1, 20);
    chk("t5 odd-ones pushed", {29'h0, cnt_b}, 32'd2);
    chk("t5 frame_err", {31'h0, fe_b}, 32'h0);

    send(fr(8'h31), 0, 20);
    send(fr(8'h32), 0, 20);
    chk("t6 queued", {29'h0, cnt_a}, 32'd2);
    fork
      send(fr(8'h35), 0, 20);
      begin
        repeat (400) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t6 reset valid", {31'h0, val_a}, 32'h0);
        chk("t6 reset count", {29'h0, cnt_a}, 32'h0);
        chk("t6 reset data", {24'h0, data_a}, 32'h0);
        chk("t6 reset flags", {29'h0, fe_a, pe_a, ov_a}, 32'h0);
        chk("t6 reset parity dut", {28'h0, cnt_b, pe_b}, 32'h0);
      end
    join
    reset = 1'b0;
    repeat (5) @(negedge clk);
    send(fr(8'h37), 0, 20);
    chk("t6 after reset valid", {31'h0, val_a}, 32'h1);
    chk("t6 after reset data", {24'h0, data_a}, 32'h37);
    chk("t6 after reset count", {29'h0, cnt_a}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
